snn_mem_arbiter: RTL and testbench
==================================

SNN_MEM_ARBITER -- requirements
Module: snn_mem_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_MAX, default 32, giving the maximum consecutive grants to one locked requester.
REQ-002 The block SHALL have parameter WR_LO, default 16'hE000, giving the lowest address requesters 1-2 may write.
REQ-003 The block SHALL have parameter WR_HI, default 16'hFFFF, giving the highest address requesters 1-2 may write.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  3  per-requester access request (0=host loader, 1=neuron core, 2=spike logger).
REQ-007 lock  in  3  per-requester burst hold, qualified by req.
REQ-008 we_in  in  3  per-requester write enable.
REQ-009 addr_in  in  48  three packed 16-bit addresses, requester i at [16i+:16].
REQ-010 wdata_in  in  96  three packed 32-bit write words, requester i at [32i+:32].
REQ-011 gnt  out  3  one-hot combinational accept; request consumed in the cycle gnt[i]=1.
REQ-012 rvalid  out  3  one-hot read-data-valid strobe.
REQ-013 rdata  out  32  read data, valid while any rvalid bit is 1.
REQ-014 err  out  1  one-cycle pulse on a blocked write.
REQ-015 err_id  out  2  requester index of the last blocked write.
REQ-016 mem_we / mem_addr / mem_wdata  out  1/16/32  registered single-port memory command.
REQ-017 mem_rdata  in  32  memory read data; the memory registers it one clock after sampling mem_addr.

Function
REQ-018 At most one gnt bit SHALL be 1 per cycle; gnt SHALL be 0 when req is 0.
REQ-019 Arbitration SHALL be round-robin: search starts at index rr_ptr and wraps 2->0; after an unlocked grant to i, rr_ptr becomes (i+1) mod 3.
REQ-020 While owner o has req[o]&lock[o] and lock_cnt < LOCK_MAX, gnt SHALL go to o regardless of rr_ptr and rr_ptr SHALL NOT advance.
REQ-021 lock_cnt SHALL count consecutive locked grants to o; on the LOCK_MAX-th grant, rr_ptr becomes (o+1) mod 3 and lock_cnt clears, forcing one round-robin pass before o may lock again.
REQ-022 Ownership SHALL end and lock_cnt clear in any cycle where the owner drops req or lock.
REQ-023 On gnt[i] in cycle T, mem_addr/mem_wdata/mem_we SHALL present requester i's command in cycle T+1; mem_we SHALL be 0 in T+1 when no grant occurred in T.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when no grant occurs.
REQ-025 A granted read in cycle T SHALL produce rvalid[i]=1 and rdata=mem_rdata in exactly cycle T+2; sustained throughput one access per cycle.
REQ-026 A write from requester 1 or 2 with address outside [WR_LO, WR_HI] SHALL still be granted, SHALL drive mem_we=0 in T+1, and SHALL pulse err with err_id=i in T+1.
REQ-027 Requester 0 writes SHALL never be blocked.
REQ-028 Writes SHALL NOT generate rvalid.

Reset
REQ-029 On rst: mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, rdata=0, err=0, err_id=0, rr_ptr=0, lock_cnt=0, no owner.
REQ-030 rst asserted mid-operation SHALL discard in-flight read strobes; no rvalid SHALL appear after rst for a pre-reset grant.
REQ-031 gnt SHALL be 0 in every cycle rst is high.

Structure
REQ-032 Shared package snn_pkg SHALL hold NREQ=3, requester IDs, and the address map (CFG_ADDR 16'h0008, WEIGHT_BASE 16'h4000, VMEM_BASE 16'hE000).
REQ-033 Round-robin selection SHALL be one sub-module snn_rr_picker (req[2:0], rr_ptr -> one-hot pick); lock, pipeline and protection stay in snn_mem_arbiter.

Verification
REQ-034 req=3'b111, lock=0, all reads, held 6 cycles -> gnt sequence 0,1,2,0,1,2; rvalid follows each grant by 2 cycles.
REQ-035 req[1]&lock[1] continuous, req[0] high, LOCK_MAX=4 -> four gnt[1], then one gnt[0], then gnt[1] resumes.
REQ-036 Requester 2 writes addr 16'h4000 -> gnt[2]=1, next cycle mem_we=0, err=1, err_id=2; requester 0 writes 16'h4000 -> mem_we=1, no err.
REQ-037 Requester 1 reads 16'hE004 with memory preloaded 32'h0000_0123 -> rvalid[1]=1, rdata=32'h0000_0123 two cycles after gnt.
REQ-038 Read granted, rst pulsed next cycle -> rvalid remains 0, mem_we=0, next grant after rst goes to lowest requesting index.

Source files
------------

// File: rtl/snn_pkg.sv
`timescale 1ns/1ps
// snn_pkg
// Shared definitions for the SNN memory subsystem: requester count and IDs,
// bus widths, the address map, and small index helpers used by the arbiter.
package snn_pkg;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_HOST   = 2'd0,
    REQ_CORE   = 2'd1,
    REQ_LOGGER = 2'd2
  } req_id_e;

  localparam logic [ADDR_W-1:0] CFG_ADDR    = 16'h0008;
  localparam logic [ADDR_W-1:0] WEIGHT_BASE = 16'h4000;
  localparam logic [ADDR_W-1:0] VMEM_BASE   = 16'hE000;

  // Successor in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [1:0] oh_to_idx(input logic [NREQ-1:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [NREQ-1:0] idx_to_oh(input logic [1:0] i);
    case (i)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/snn_mem_arbiter_if.sv
`timescale 1ns/1ps
// snn_mem_arbiter_if
// Requester-side bus of the SNN memory arbiter.
//   req/lock/we_in   per-requester request, burst hold, write enable
//   addr_in/wdata_in packed per-requester address (16b) and write word (32b)
//   gnt/rvalid       one-hot accept and read-data strobe
//   rdata            read data, valid while any rvalid bit is set
//   err/err_id       blocked-write pulse and offending requester index
// master: requester side, slave: arbiter side.
interface snn_mem_arbiter_if;
  import snn_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        we_in;
  logic [NREQ*ADDR_W-1:0] addr_in;
  logic [NREQ*DATA_W-1:0] wdata_in;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic [1:0]             err_id;

  modport master (
    output req, lock, we_in, addr_in, wdata_in,
    input  gnt, rvalid, rdata, err, err_id
  );

  modport slave (
    input  req, lock, we_in, addr_in, wdata_in,
    output gnt, rvalid, rdata, err, err_id
  );

endinterface

// File: rtl/snn_rr_picker.sv
`timescale 1ns/1ps
// snn_rr_picker
// Combinational round-robin selector: scans req starting at rr_ptr, wrapping
// 2 -> 0, and returns a one-hot pick of the first active requester.
//   req    active requests
//   rr_ptr index searched first (0..2)
//   pick   one-hot winner, zero when req is zero
module snn_rr_picker
  import snn_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      rr_ptr,
  output logic [NREQ-1:0] pick
);

  logic [1:0] i0, i1, i2;

  always_comb begin
    i0   = 2'd0;
    i1   = 2'd1;
    i2   = 2'd2;
    pick = '0;
    case (rr_ptr)
      2'd1: begin i0 = 2'd1; i1 = 2'd2; i2 = 2'd0; end
      2'd2: begin i0 = 2'd2; i1 = 2'd0; i2 = 2'd1; end
      default: ;
    endcase
    if (req[i0])      pick[i0] = 1'b1;
    else if (req[i1]) pick[i1] = 1'b1;
    else if (req[i2]) pick[i2] = 1'b1;
  end

endmodule

// File: rtl/snn_mem_arbiter.sv
`timescale 1ns/1ps
// snn_mem_arbiter
// Three-requester arbiter in front of a single-port synchronous memory.
// Round-robin grant with optional bounded burst lock, a one-stage registered
// memory command, and write protection for requesters 1-2 outside
// [WR_LO, WR_HI]. Reads return rvalid/rdata two cycles after the grant.
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       requester-side bus, see snn_mem_arbiter_if
//   mem_we/addr/wdata registered memory command
//   mem_rdata         memory read data, registered by the memory
module snn_mem_arbiter
  import snn_pkg::*;
#(
  parameter int                LOCK_MAX = 32,
  parameter logic [ADDR_W-1:0] WR_LO    = VMEM_BASE,
  parameter logic [ADDR_W-1:0] WR_HI    = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  snn_mem_arbiter_if.slave  bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Compared one bit wider so a window edge at 0 or 16'hFFFF stays a real
  // comparison rather than collapsing to a constant.
  function automatic logic wr_allowed(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax, lo, hi;
    ax = {1'b0, a};
    lo = {1'b0, WR_LO};
    hi = {1'b0, WR_HI};
    return (ax >= lo) && (ax <= hi);
  endfunction

  logic [1:0]        rr_ptr;
  logic [1:0]        owner;
  logic              owner_vld;
  logic [CNT_W-1:0]  lock_cnt;

  logic [NREQ-1:0]   pick;
  logic [NREQ-1:0]   gnt_c;
  logic              hold;
  logic              gnt_any;
  logic [1:0]        gnt_idx;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_lock;
  logic              sel_blk;

  logic              mem_we_p0;
  logic [ADDR_W-1:0] mem_addr_p0;
  logic [DATA_W-1:0] mem_wdata_p0;
  logic              err_p0;
  logic [1:0]        err_id_p0;
  logic [NREQ-1:0]   rd_vld_p0;
  logic [NREQ-1:0]   rvalid_p1;

  snn_rr_picker u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // A live owner keeps the grant until it drops req/lock; the counter is
  // cleared on the final burst grant so hold never sees lock_cnt == LOCK_MAX.
  always_comb begin
    hold    = owner_vld && bus.req[owner] && bus.lock[owner] && (lock_cnt < CNT_MAX);
    gnt_c   = '0;
    if (!rst) gnt_c = hold ? idx_to_oh(owner) : pick;
    gnt_any = |gnt_c;
    gnt_idx = oh_to_idx(gnt_c);
  end

  assign bus.gnt = gnt_c;

  always_comb begin
    sel_addr  = bus.addr_in[ADDR_W-1:0];
    sel_wdata = bus.wdata_in[DATA_W-1:0];
    sel_we    = bus.we_in[0];
    sel_lock  = bus.lock[0];
    case (gnt_idx)
      2'd1: begin
        sel_addr  = bus.addr_in[2*ADDR_W-1:ADDR_W];
        sel_wdata = bus.wdata_in[2*DATA_W-1:DATA_W];
        sel_we    = bus.we_in[1];
        sel_lock  = bus.lock[1];
      end
      2'd2: begin
        sel_addr  = bus.addr_in[3*ADDR_W-1:2*ADDR_W];
        sel_wdata = bus.wdata_in[3*DATA_W-1:2*DATA_W];
        sel_we    = bus.we_in[2];
        sel_lock  = bus.lock[2];
      end
      default: ;
    endcase
    sel_blk = sel_we && (gnt_idx != 2'(REQ_HOST)) && !wr_allowed(sel_addr);
  end

  // Arbitration state: rr_ptr only moves on round-robin grants and on burst
  // expiry; a round-robin grant with lock set opens a new burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 2'd0;
      owner     <= 2'd0;
      owner_vld <= 1'b0;
      lock_cnt  <= '0;
    end else if (hold) begin
      if (lock_cnt + CNT_ONE == CNT_MAX) begin
        owner_vld <= 1'b0;
        lock_cnt  <= '0;
        rr_ptr    <= next_idx(owner);
      end else begin
        lock_cnt  <= lock_cnt + CNT_ONE;
      end
    end else begin
      owner_vld <= 1'b0;
      lock_cnt  <= '0;
      if (gnt_any) begin
        rr_ptr <= next_idx(gnt_idx);
        if (sel_lock && (CNT_MAX != CNT_ONE)) begin
          owner     <= gnt_idx;
          owner_vld <= 1'b1;
          lock_cnt  <= CNT_ONE;
        end
      end
    end
  end

  // ---- stage p0: registered memory command, error pulse, read tag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_p0    <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      err_p0       <= 1'b0;
      err_id_p0    <= 2'd0;
      rd_vld_p0    <= '0;
    end else begin
      mem_we_p0 <= gnt_any && sel_we && !sel_blk;
      err_p0    <= gnt_any && sel_blk;
      rd_vld_p0 <= (gnt_any && !sel_we) ? gnt_c : '0;
      if (gnt_any) begin
        mem_addr_p0  <= sel_addr;
        mem_wdata_p0 <= sel_wdata;
      end
      if (gnt_any && sel_blk) err_id_p0 <= gnt_idx;
    end
  end

  // ---- stage p1: read strobe aligned with the memory's registered data ----
  always_ff @(posedge clk) begin
    if (rst) rvalid_p1 <= '0;
    else     rvalid_p1 <= rd_vld_p0;
  end

  assign mem_we      = mem_we_p0;
  assign mem_addr    = mem_addr_p0;
  assign mem_wdata   = mem_wdata_p0;
  assign bus.err     = err_p0;
  assign bus.err_id  = err_id_p0;
  assign bus.rvalid  = rvalid_p1;
  assign bus.rdata   = (|rvalid_p1) ? mem_rdata : '0;

endmodule

// File: tb/tb_snn_mem_arbiter.sv
`timescale 1ns/1ps
// tb_snn_mem_arbiter
// Directed bench for snn_mem_arbiter with a behavioural registered memory.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_snn_mem_arbiter;
  import snn_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  snn_mem_arbiter_if bus();

  snn_mem_arbiter #(
    .LOCK_MAX (4),
    .WR_LO    (16'hE000),
    .WR_HI    (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory: unwritten words return a fixed preload pattern.
  bit [31:0] mem [0:65535];
  bit        wr  [0:65535];

  function automatic logic [31:0] preload(input logic [15:0] a);
    case (a)
      16'h0010: return 32'hA0A0_0010;
      16'h0020: return 32'hA1A1_0020;
      16'h0030: return 32'hA2A2_0030;
      16'hE004: return 32'h0000_0123;
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr]  <= 1'b1;
    end
    mem_rdata <= wr[mem_addr] ? mem[mem_addr] : preload(mem_addr);
  end

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [2:0] oh(input int i);
    return 3'b001 << i;
  endfunction

  logic [31:0] rr_data [0:2];
  logic [2:0]  lock_seq [0:4];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rr_data[0] = 32'hA0A0_0010;
    rr_data[1] = 32'hA1A1_0020;
    rr_data[2] = 32'hA2A2_0030;
    lock_seq[0] = 3'b010; lock_seq[1] = 3'b010; lock_seq[2] = 3'b010;
    lock_seq[3] = 3'b001; lock_seq[4] = 3'b010;

    rst          = 1'b1;
    bus.req      = '0;
    bus.lock     = '0;
    bus.we_in    = '0;
    bus.addr_in  = '0;
    bus.wdata_in = '0;
    repeat (2) @(negedge clk);

    // Reset state
    bus.req = 3'b111;
    #1;
    check("gnt_during_rst", bus.gnt, 3'b000);
    @(negedge clk);
    #1;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rvalid", bus.rvalid, 3'b000);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_err", bus.err, 1'b0);
    check("rst_err_id", bus.err_id, 2'd0);

    // Round robin, all reads, six cycles
    bus.addr_in = {16'h0030, 16'h0020, 16'h0010};
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.req = (k < 6) ? 3'b111 : 3'b000;
      #1;
      check($sformatf("rr_gnt[%0d]", k), bus.gnt, (k < 6) ? oh(k % 3) : 3'b000);
      check($sformatf("rr_rvalid[%0d]", k), bus.rvalid, (k >= 2) ? oh((k - 2) % 3) : 3'b000);
      if (k >= 2) check($sformatf("rr_rdata[%0d]", k), bus.rdata, rr_data[(k - 2) % 3]);
      if (k >= 1 && k <= 6)
        check($sformatf("rr_mem_addr[%0d]", k), mem_addr, 16'h0010 + 16'h0010 * 16'((k - 1) % 3));
      @(negedge clk);
    end

    // Locked burst on requester 1 with LOCK_MAX = 4
    bus.req  = 3'b010;
    bus.lock = 3'b010;
    #1;
    check("lock_gnt_first", bus.gnt, 3'b010);
    @(negedge clk);
    bus.req = 3'b011;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("lock_gnt[%0d]", k), bus.gnt, lock_seq[k]);
      @(negedge clk);
    end
    // Owner drops lock: ownership ends, rr_ptr=2 so requester 0 wins
    bus.lock = 3'b000;
    #1;
    check("lock_drop_gnt", bus.gnt, 3'b001);
    @(negedge clk);

    // Blocked write from requester 2
    bus.req      = 3'b100;
    bus.we_in    = 3'b100;
    bus.addr_in  = {WEIGHT_BASE, 16'h0000, 16'h0000};
    bus.wdata_in = {32'hDEAD_BEEF, 32'h0, 32'h0};
    #1;
    check("blk_gnt", bus.gnt, 3'b100);
    @(negedge clk);
    bus.req   = 3'b000;
    bus.we_in = 3'b000;
    #1;
    check("blk_mem_we", mem_we, 1'b0);
    check("blk_err", bus.err, 1'b1);
    check("blk_err_id", bus.err_id, 2'd2);
    check("blk_mem_addr", mem_addr, 16'h4000);
    @(negedge clk);
    #1;
    check("blk_err_pulse", bus.err, 1'b0);
    check("blk_err_id_hold", bus.err_id, 2'd2);
    check("blk_no_rvalid", bus.rvalid, 3'b000);

    // Host write to the same address is never blocked
    bus.req      = 3'b001;
    bus.we_in    = 3'b001;
    bus.addr_in  = {16'h0000, 16'h0000, 16'h4000};
    bus.wdata_in = {32'h0, 32'h0, 32'hCAFE_F00D};
    #1;
    check("host_wr_gnt", bus.gnt, 3'b001);
    @(negedge clk);
    bus.req   = 3'b000;
    bus.we_in = 3'b000;
    #1;
    check("host_wr_mem_we", mem_we, 1'b1);
    check("host_wr_mem_addr", mem_addr, 16'h4000);
    check("host_wr_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    check("host_wr_err", bus.err, 1'b0);
    @(negedge clk);

    // Window edges for requester 1: 16'hDFFF blocked, 16'hE000 allowed
    bus.req      = 3'b010;
    bus.we_in    = 3'b010;
    bus.addr_in  = {16'h0000, 16'hDFFF, 16'h0000};
    bus.wdata_in = {32'h0, 32'h1111_2222, 32'h0};
    #1;
    check("edge_lo_gnt", bus.gnt, 3'b010);
    @(negedge clk);
    bus.addr_in = {16'h0000, VMEM_BASE, 16'h0000};
    #1;
    check("edge_lo_err", bus.err, 1'b1);
    check("edge_lo_err_id", bus.err_id, 2'd1);
    check("edge_lo_mem_we", mem_we, 1'b0);
    check("edge_in_gnt", bus.gnt, 3'b010);
    @(negedge clk);
    bus.req   = 3'b000;
    bus.we_in = 3'b000;
    #1;
    check("edge_in_mem_we", mem_we, 1'b1);
    check("edge_in_err", bus.err, 1'b0);
    check("edge_in_mem_addr", mem_addr, 16'hE000);
    check("edge_in_err_id_hold", bus.err_id, 2'd1);
    @(negedge clk);

    // Host reads back its write: strobe exactly two cycles after grant
    bus.req     = 3'b001;
    bus.addr_in = {16'h0000, 16'h0000, 16'h4000};
    #1;
    check("rb_gnt", bus.gnt, 3'b001);
    @(negedge clk);
    bus.req = 3'b000;
    #1;
    check("rb_rvalid_t1", bus.rvalid, 3'b000);
    @(negedge clk);
    #1;
    check("rb_rvalid_t2", bus.rvalid, 3'b001);
    check("rb_rdata", bus.rdata, 32'hCAFE_F00D);
    @(negedge clk);

    // Requester 1 reads preloaded neuron state
    bus.req     = 3'b010;
    bus.addr_in = {16'h0000, 16'hE004, 16'h0000};
    #1;
    check("vmem_gnt", bus.gnt, 3'b010);
    @(negedge clk);
    bus.req = 3'b000;
    #1;
    check("vmem_rvalid_t1", bus.rvalid, 3'b000);
    @(negedge clk);
    #1;
    check("vmem_rvalid", bus.rvalid, 3'b010);
    check("vmem_rdata", bus.rdata, 32'h0000_0123);
    @(negedge clk);
    #1;
    check("vmem_rvalid_end", bus.rvalid, 3'b000);
    check("vmem_rdata_end", bus.rdata, 32'h0);

    // Read granted, then reset pulsed: in-flight strobe is discarded
    bus.req     = 3'b010;
    bus.addr_in = {16'h0030, 16'h0020, 16'h0010};
    #1;
    check("rst_mid_gnt", bus.gnt, 3'b010);
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 3'b111;
    #1;
    check("rst_mid_gnt_zero", bus.gnt, 3'b000);
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 3'b111;
    #1;
    check("rst_mid_rvalid", bus.rvalid, 3'b000);
    check("rst_mid_mem_we", mem_we, 1'b0);
    check("rst_mid_mem_addr", mem_addr, 16'h0);
    check("rst_mid_next_gnt", bus.gnt, 3'b001);
    @(negedge clk);
    bus.req = 3'b000;
    #1;
    check("rst_mid_rvalid_t1", bus.rvalid, 3'b000);
    @(negedge clk);
    #1;
    check("rst_mid_post_rvalid", bus.rvalid, 3'b001);
    check("rst_mid_post_rdata", bus.rdata, 32'hA0A0_0010);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
